// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel readout arbiter.
package pixel_readout_pkg;

    localparam int   ADDR_W    = 15;
    localparam int   HIT_W     = ADDR_W + 1;
    localparam logic BANK_UP   = 1'b1;
    localparam logic BANK_DOWN = 1'b0;

    // ARB picks a bank, GRANT pulses its read and captures the hit,
    // SETTLE leaves the encoder one cycle to present its next pixel.
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through hit buffer with occupancy, full and empty flags.
module hit_fifo #(
    parameter int WIDTH = pixel_readout_pkg::HIT_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);
    assign level = level_q;
    // The head reads as zero while empty so the output is clean after reset.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy updates; a push into a full FIFO is only taken
    // when the head is leaving in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its input from before the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the occupancy
        // count decides which entries are meaningful.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_readout_arbiter.sv
// Round-robin readout of the up/down priority-encoder banks into one tagged
// hit stream, buffered in a FWFT FIFO drained by a valid/ready consumer.
module pixel_readout_arbiter #(
    parameter int ADDR_W     = pixel_readout_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clock,
    input  logic                          sys_reset,
    input  logic                          readout_en,
    input  logic                          up_valid_i,
    input  logic [ADDR_W-1:0]             up_addr_i,
    input  logic                          down_valid_i,
    input  logic [ADDR_W-1:0]             down_addr_i,
    output logic                          up_rd_en_o,
    output logic                          down_rd_en_o,
    output logic [ADDR_W:0]               hit_data_o,
    output logic                          hit_valid_o,
    input  logic                          hit_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   hit_count_o,
    output logic                          busy_o
);

    import pixel_readout_pkg::*;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            up_rd_en_q, up_rd_en_d;
    logic            down_rd_en_q, down_rd_en_d;
    logic [15:0]     hit_count_q, hit_count_d;
    logic            up_elig, down_elig, grant_bank;
    logic            push;
    logic [ADDR_W:0] push_data;
    logic            pop;
    logic            fifo_full, fifo_empty;

    // Arbitration, read-pulse scheduling and hit capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        up_rd_en_d   = 1'b0;
        down_rd_en_d = 1'b0;
        hit_count_d  = hit_count_q;
        push         = 1'b0;
        // In GRANT, last_grant_q is the bank being read this cycle.
        push_data    = {last_grant_q, (last_grant_q == BANK_UP) ? up_addr_i : down_addr_i};
        up_elig      = readout_en && up_valid_i && !fifo_full;
        down_elig    = readout_en && down_valid_i && !fifo_full;
        if (up_elig && down_elig) begin
            grant_bank = ~last_grant_q;
        end else begin
            grant_bank = up_elig ? BANK_UP : BANK_DOWN;
        end

        case (state_q)
            ARB: begin
                if (up_elig || down_elig) begin
                    state_d      = GRANT;
                    last_grant_d = grant_bank;
                    up_rd_en_d   = (grant_bank == BANK_UP);
                    down_rd_en_d = (grant_bank == BANK_DOWN);
                end
            end
            GRANT: begin
                // Space was checked in ARB and pops only free entries.
                push        = 1'b1;
                hit_count_d = hit_count_q + 16'd1;
                state_d     = SETTLE;
            end
            SETTLE: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // FSM, round-robin pointer, read-pulse flops and hit counter.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q      <= ARB;
            last_grant_q <= BANK_DOWN;
            up_rd_en_q   <= 1'b0;
            down_rd_en_q <= 1'b0;
            hit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            up_rd_en_q   <= up_rd_en_d;
            down_rd_en_q <= down_rd_en_d;
            hit_count_q  <= hit_count_d;
        end
    end

    assign pop = hit_valid_o && hit_ready_i;

    hit_fifo #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk       (sys_clock),
        .rst       (sys_reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (hit_data_o),
        .level     (fifo_level_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign up_rd_en_o   = up_rd_en_q;
    assign down_rd_en_o = down_rd_en_q;
    assign hit_valid_o  = !fifo_empty;
    assign hit_count_o  = hit_count_q;
    assign busy_o       = (state_q != ARB) || !fifo_empty;

endmodule

// File: tb/tb_pixel_readout_arbiter.sv
// Bench for pixel_readout_arbiter: bank encoders modelled as address queues,
// expected hit stream kept as a queue, directed scenarios plus random traffic.
module tb_pixel_readout_arbiter;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              readout_en = 1'b0;
    logic              up_valid_i = 1'b0;
    logic [ADDR_W-1:0] up_addr_i = '0;
    logic              down_valid_i = 1'b0;
    logic [ADDR_W-1:0] down_addr_i = '0;
    logic              hit_ready_i = 1'b0;
    logic              up_rd_en_o, down_rd_en_o, hit_valid_o, busy_o;
    logic [ADDR_W:0]   hit_data_o;
    logic [3:0]        fifo_level_o;
    logic [15:0]       hit_count_o;

    always #5 clk = ~clk;

    pixel_readout_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clock    (clk),
        .sys_reset    (rst),
        .readout_en   (readout_en),
        .up_valid_i   (up_valid_i),
        .up_addr_i    (up_addr_i),
        .down_valid_i (down_valid_i),
        .down_addr_i  (down_addr_i),
        .up_rd_en_o   (up_rd_en_o),
        .down_rd_en_o (down_rd_en_o),
        .hit_data_o   (hit_data_o),
        .hit_valid_o  (hit_valid_o),
        .hit_ready_i  (hit_ready_i),
        .fifo_level_o (fifo_level_o),
        .hit_count_o  (hit_count_o),
        .busy_o       (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [ADDR_W-1:0] up_q[$];
    logic [ADDR_W-1:0] down_q[$];
    logic [ADDR_W:0]   exp_q[$];
    logic [ADDR_W:0]   out_log[$];
    logic [15:0]       exp_count = '0;
    logic              last_grant_m = 1'b0;
    logic              last_pulse_bank = 1'b0;
    int                pending_pop = -1;
    int                n_pulse = 0;
    int                cyc = 0;
    int                last_pulse_cyc = 0;
    bit                rand_ready = 1'b0;
    logic              ready_lvl = 1'b1;
    logic              m_pulse, m_bank, m_exp_bank;
    logic [ADDR_W:0]   m_hit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(up_q.size() == 0 && down_q.size() == 0 && exp_q.size() == 0 && busy_o == 1'b0)
               && k < budget) begin
            tick(1);
            k++;
        end
        check("idle_timeout", 32'(k < budget), 32'd1);
    endtask

    // Scoreboard and encoder model, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        m_pulse = 1'b0;
        if (rst) begin
            if (pending_pop == 1) void'(up_q.pop_front());
            else if (pending_pop == 0) void'(down_q.pop_front());
            pending_pop  = -1;
            exp_q.delete();
            exp_count    = '0;
            last_grant_m = 1'b0;
        end else begin
            check("hit_valid", 32'(hit_valid_o), 32'(exp_q.size() != 0));
            check("fifo_level", 32'(fifo_level_o), 32'(exp_q.size()));
            check("hit_count", 32'(hit_count_o), 32'(exp_count));
            check("rd_en_exclusive", 32'(up_rd_en_o & down_rd_en_o), 32'd0);
            if (exp_q.size() != 0) begin
                check("hit_data", 32'(hit_data_o), 32'(exp_q[0]));
                check("busy_fifo", 32'(busy_o), 32'd1);
            end
            // The encoder clears the pixel read in the previous cycle.
            if (pending_pop == 1) void'(up_q.pop_front());
            else if (pending_pop == 0) void'(down_q.pop_front());
            pending_pop = -1;
            if (up_rd_en_o || down_rd_en_o) begin
                m_pulse    = 1'b1;
                m_bank     = up_rd_en_o;
                m_exp_bank = (up_valid_i && down_valid_i) ? ~last_grant_m : up_valid_i;
                check("grant_bank", 32'(m_bank), 32'(m_exp_bank));
                check("grant_valid", 32'(m_bank ? up_valid_i : down_valid_i), 32'd1);
                check("pulse_spacing", 32'(n_pulse == 0 || cyc - last_pulse_cyc >= 3), 32'd1);
                check("space_at_grant", 32'(exp_q.size() < DEPTH), 32'd1);
                check("busy_grant", 32'(busy_o), 32'd1);
                m_hit = {m_bank, m_bank ? up_addr_i : down_addr_i};
                exp_count++;
                n_pulse++;
                last_pulse_cyc  = cyc;
                last_grant_m    = m_bank;
                last_pulse_bank = m_bank;
                pending_pop     = m_bank ? 1 : 0;
            end
        end
        up_valid_i   = (up_q.size() != 0);
        up_addr_i    = up_valid_i ? up_q[0] : '0;
        down_valid_i = (down_q.size() != 0);
        down_addr_i  = down_valid_i ? down_q[0] : '0;
        hit_ready_i  = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
        if (!rst && exp_q.size() != 0 && hit_ready_i) out_log.push_back(exp_q.pop_front());
        if (m_pulse) exp_q.push_back(m_hit);
    end

    initial begin
        logic [15:0] exp_c [6];
        logic [15:0] c0;
        int          p0;
        int          k;
        exp_c = '{16'h8010, 16'h0020, 16'h8011, 16'h0021, 16'h8012, 16'h0022};

        // Reset state.
        tick(3);
        check("rst_up_rd", 32'(up_rd_en_o), 32'd0);
        check("rst_down_rd", 32'(down_rd_en_o), 32'd0);
        check("rst_valid", 32'(hit_valid_o), 32'd0);
        check("rst_data", 32'(hit_data_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        check("rst_count", 32'(hit_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Contention: up wins the first tie, then strict alternation.
        rst = 1'b0;
        readout_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_q.push_back(15'(16'h10 + i));
            down_q.push_back(15'(16'h20 + i));
        end
        out_log.delete();
        wait_idle(100);
        check("contention_len", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            check("contention_order", 32'(out_log[i]), 32'(exp_c[i]));
        end

        // Single hit: pulse one cycle after eligibility, data one cycle later.
        c0 = hit_count_o;
        up_q.push_back(15'h1234);
        tick(1);
        check("single_rd_pulse", 32'(up_rd_en_o), 32'd1);
        check("single_not_yet_valid", 32'(hit_valid_o), 32'd0);
        tick(1);
        check("single_rd_done", 32'(up_rd_en_o), 32'd0);
        check("single_valid", 32'(hit_valid_o), 32'd1);
        check("single_data", 32'(hit_data_o), 32'h9234);
        check("single_count", 32'(hit_count_o), 32'(c0 + 16'd1));
        wait_idle(50);

        // Backpressure: exactly DEPTH grants, then one pop lets one more through.
        ready_lvl = 1'b0;
        p0 = n_pulse;
        for (int i = 0; i < 10; i++) up_q.push_back(15'(16'h100 + i));
        tick(40);
        check("bp_grants", 32'(n_pulse - p0), 32'd8);
        check("bp_level", 32'(fifo_level_o), 32'd8);
        tick(10);
        check("bp_stalled", 32'(n_pulse - p0), 32'd8);
        ready_lvl = 1'b1;
        tick(1);
        ready_lvl = 1'b0;
        tick(3);
        check("bp_resume", 32'(n_pulse - p0), 32'd9);
        ready_lvl = 1'b1;
        wait_idle(200);

        // Enable dropped in GRANT: that hit completes, nothing further.
        for (int i = 0; i < 3; i++) up_q.push_back(15'(16'h400 + i));
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!up_rd_en_o && k < 10);
        check("en_drop_pulse_seen", 32'(up_rd_en_o), 32'd1);
        readout_en = 1'b0;
        p0 = n_pulse;
        tick(15);
        check("en_drop_no_pulse", 32'(n_pulse - p0), 32'd1);
        check("en_drop_level", 32'(fifo_level_o), 32'd0);
        check("en_drop_busy", 32'(busy_o), 32'd0);
        check("en_drop_left", 32'(up_q.size()), 32'd2);
        readout_en = 1'b1;
        wait_idle(100);

        // Reset in SETTLE with three hits buffered.
        ready_lvl = 1'b0;
        p0 = n_pulse;
        for (int i = 0; i < 3; i++) begin
            up_q.push_back(15'(16'h200 + i));
            down_q.push_back(15'(16'h300 + i));
        end
        k = 0;
        do begin
            tick(1);
            k++;
        end while (n_pulse - p0 < 3 && k < 50);
        check("pre_rst_level", 32'(fifo_level_o), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_up_rd", 32'(up_rd_en_o), 32'd0);
        check("mid_rst_down_rd", 32'(down_rd_en_o), 32'd0);
        check("mid_rst_valid", 32'(hit_valid_o), 32'd0);
        check("mid_rst_data", 32'(hit_data_o), 32'd0);
        check("mid_rst_level", 32'(fifo_level_o), 32'd0);
        check("mid_rst_count", 32'(hit_count_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        tick(2);
        rst = 1'b0;
        ready_lvl = 1'b1;
        p0 = n_pulse;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (n_pulse == p0 && k < 20);
        check("post_rst_first_up", 32'(last_pulse_bank), 32'd1);
        wait_idle(100);

        // Counter wrap.
        force dut.hit_count_q = 16'hFFFE;
        exp_count = 16'hFFFE;
        tick(1);
        release dut.hit_count_q;
        tick(1);
        check("wrap_preset", 32'(hit_count_o), 32'hFFFE);
        for (int i = 0; i < 3; i++) up_q.push_back(15'(16'h500 + i));
        wait_idle(100);
        check("wrap_count", 32'(hit_count_o), 32'h0001);

        // Random traffic, random backpressure and enable.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            readout_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) up_q.push_back(15'($urandom));
            if ($urandom_range(0, 5) == 0) down_q.push_back(15'($urandom));
        end
        readout_en = 1'b1;
        wait_idle(3000);
        check("random_drained", 32'(up_q.size() + down_q.size() + exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
